// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction image loader.
package LoaderType;

   localparam int HDR_BYTES  = 2;   // big-endian word count header
   localparam int WORD_BYTES = 4;   // bytes per instruction word

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA,
      WRITE,
      CHECK,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Packs a big-endian byte stream into 32-bit words. word_ready_o pulses
// combinationally on the 4th byte of a word, with word_o already holding the
// complete word (the current byte forms the low byte).
module byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear_i,
   input  logic        shift_en_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_ready_o
);

   logic [1:0]  cnt_q;
   logic [23:0] shift_q;

   assign word_o       = {shift_q, byte_i};
   assign word_ready_o = shift_en_i && (cnt_q == 2'd3);

   // Shift in accepted bytes; the 2-bit count wraps 3->0 on each word boundary.
   always_ff @(posedge clk) begin
      if (!rst || clear_i) begin
         cnt_q   <= 2'd0;
         shift_q <= 24'd0;
      end else if (shift_en_i) begin
         cnt_q   <= cnt_q + 2'd1;
         shift_q <= {shift_q[15:0], byte_i};
      end
   end

endmodule

// File: rtl/inst_loader.sv
// Instruction image loader: receives a length-prefixed big-endian byte stream,
// writes packed words to instruction memory and holds the CPU in reset until
// the image is complete.
// Optional feature macro: LOADER_CHECKSUM_EN (32-bit sum trailer after the image).
module inst_loader
   import LoaderType::*;
#(
   parameter int          MAX_WORDS = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        load,
   output logic [31:0] load_addr,
   output logic [31:0] load_inst,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   localparam int LenW = 8 * HDR_BYTES;
   localparam logic [LenW-1:0] MaxLen = LenW'(MAX_WORDS);

   state_t            state_q;
   logic [LenW-1:0]   len_q;
   logic [LenW-1:0]   idx_q;
   logic              load_q;
   logic [31:0]       load_addr_q;
   logic [31:0]       load_inst_q;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]       sum_q;
`endif

   logic              xfer;
   logic              pack_en;
   logic              pack_clear;
   logic [31:0]       packed_word;
   logic              word_ready;
   logic [LenW-1:0]   hdr_len;
   logic [LenW-1:0]   idx_next;

   assign byte_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                       (state_q == DATA)   || (state_q == CHECK);
   assign xfer       = byte_valid && byte_ready;
   assign pack_en    = xfer && ((state_q == DATA) || (state_q == CHECK));
   assign pack_clear = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
   assign hdr_len    = {len_q[LenW-1:8], byte_data};
   assign idx_next   = idx_q + LenW'(1);

   assign load      = load_q;
   assign load_addr = load_addr_q;
   assign load_inst = load_inst_q;
   assign cpu_hold  = (state_q != DONE);
   assign done      = (state_q == DONE);
   assign error     = (state_q == ERR);

   byte_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (pack_clear),
      .shift_en_i   (pack_en),
      .byte_i       (byte_data),
      .word_o       (packed_word),
      .word_ready_o (word_ready)
   );

   // Loader FSM with registered write port; load is a single-cycle strobe in WRITE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         len_q       <= '0;
         idx_q       <= '0;
         load_q      <= 1'b0;
         load_addr_q <= BASE_ADDR;
         load_inst_q <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
         sum_q       <= 32'd0;
`endif
      end else begin
         load_q <= 1'b0;
         case (state_q)
            IDLE, DONE, ERR: begin
               if (start) begin
                  state_q <= LEN_HI;
                  idx_q   <= '0;
                  len_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
                  sum_q   <= 32'd0;
`endif
               end
            end
            LEN_HI: begin
               if (xfer) begin
                  len_q[LenW-1:8] <= byte_data;
                  state_q         <= LEN_LO;
               end
            end
            LEN_LO: begin
               if (xfer) begin
                  len_q <= hdr_len;
                  if (hdr_len == '0 || hdr_len > MaxLen) state_q <= ERR;
                  else                                   state_q <= DATA;
               end
            end
            DATA: begin
               if (word_ready) begin
                  load_q      <= 1'b1;
                  load_inst_q <= packed_word;
                  load_addr_q <= BASE_ADDR + 32'(idx_q) * 32'(WORD_BYTES);
                  state_q     <= WRITE;
`ifdef LOADER_CHECKSUM_EN
                  sum_q       <= sum_q + packed_word;
`endif
               end
            end
            WRITE: begin
               idx_q <= idx_next;
               if (idx_next == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                  state_q <= CHECK;
`else
                  state_q <= DONE;
`endif
               end else begin
                  state_q <= DATA;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
               if (word_ready) state_q <= (packed_word == sum_q) ? DONE : ERR;
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader (default build or LOADER_CHECKSUM_EN).
module tb_inst_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        load;
   logic [31:0] load_addr;
   logic [31:0] load_inst;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_xfer = -1;
   logic load_prev = 1'b0;
   logic [31:0] addr_log[$];
   logic [31:0] inst_log[$];
   logic [7:0]  stream[$];

   inst_loader #(.MAX_WORDS(256), .BASE_ADDR(32'h0)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .load       (load),
      .load_addr  (load_addr),
      .load_inst  (load_inst),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%08h", tag, got);
      end
   endtask

   // Write monitor: logs every load, checks its latency, width and byte_ready.
   always @(negedge clk) begin
      if (load) begin
         addr_log.push_back(load_addr);
         inst_log.push_back(load_inst);
         check_eq("load_latency", cyc, last_xfer);
         check_eq("ready_in_write", {31'd0, byte_ready}, 32'd0);
         check_eq("load_one_cycle", {31'd0, load_prev}, 32'd0);
      end
      load_prev = load;
   end

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready) check_eq("ready_timeout", {31'd0, byte_ready}, 32'd1);
      last_xfer = cyc + 1;
      @(negedge clk);
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic push_word(input logic [31:0] w);
      stream.push_back(w[31:24]);
      stream.push_back(w[23:16]);
      stream.push_back(w[15:8]);
      stream.push_back(w[7:0]);
   endtask

   task automatic push_hdr(input logic [15:0] n);
      stream.push_back(n[15:8]);
      stream.push_back(n[7:0]);
   endtask

   task automatic send_stream(input int gap);
      while (stream.size() > 0) send_byte(stream.pop_front(), gap);
   endtask

   task automatic wait_end();
      int n = 0;
      while (!(done || error) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("end_reached", {31'd0, done | error}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
      check_eq({tag, "_load"},  {31'd0, load}, 32'd0);
      check_eq({tag, "_addr"},  load_addr, 32'h0);
      check_eq({tag, "_inst"},  load_inst, 32'h0);
      check_eq({tag, "_hold"},  {31'd0, cpu_hold}, 32'd1);
      check_eq({tag, "_done"},  {31'd0, done}, 32'd0);
      check_eq({tag, "_error"}, {31'd0, error}, 32'd0);
   endtask

   // Standard two-word image: 20080005, 00000008 (sum 2008000D).
   task automatic push_image2(input logic [31:0] trailer);
      push_hdr(16'd2);
      push_word(32'h2008_0005);
      push_word(32'h0000_0008);
`ifdef LOADER_CHECKSUM_EN
      push_word(trailer);
`else
      if (trailer != 32'h0) begin end
`endif
   endtask

   task automatic check_image2(input string tag, input int base);
      check_eq({tag, "_nloads"}, 32'(addr_log.size() - base), 32'd2);
      if (addr_log.size() >= base + 2) begin
         check_eq({tag, "_addr0"}, addr_log[base],     32'h0);
         check_eq({tag, "_inst0"}, inst_log[base],     32'h2008_0005);
         check_eq({tag, "_addr1"}, addr_log[base + 1], 32'h4);
         check_eq({tag, "_inst1"}, inst_log[base + 1], 32'h0000_0008);
      end
   endtask

   initial begin
      int base;
      rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      @(negedge clk);

      // 1: basic two-word image
      base = addr_log.size();
      pulse_start();
      push_image2(32'h2008_000D);
      send_stream(0);
      wait_end();
      check_image2("t1", base);
      check_eq("t1_done", {31'd0, done}, 32'd1);
      check_eq("t1_error", {31'd0, error}, 32'd0);
      check_eq("t1_hold", {31'd0, cpu_hold}, 32'd0);

      // 2: same image with byte_valid low every other cycle
      base = addr_log.size();
      pulse_start();
      check_eq("t2_hold_on_start", {31'd0, cpu_hold}, 32'd1);
      push_image2(32'h2008_000D);
      send_stream(1);
      wait_end();
      check_image2("t2", base);
      check_eq("t2_done", {31'd0, done}, 32'd1);

      // 3: zero-length and oversize headers, then a valid one-word image
      base = addr_log.size();
      pulse_start();
      push_hdr(16'd0);
      send_stream(0);
      wait_end();
      check_eq("t3a_error", {31'd0, error}, 32'd1);
      check_eq("t3a_done", {31'd0, done}, 32'd0);
      check_eq("t3a_hold", {31'd0, cpu_hold}, 32'd1);
      pulse_start();
      check_eq("t3b_error_clr", {31'd0, error}, 32'd0);
      push_hdr(16'd257);
      send_stream(0);
      wait_end();
      check_eq("t3b_error", {31'd0, error}, 32'd1);
      check_eq("t3b_hold", {31'd0, cpu_hold}, 32'd1);
      check_eq("t3_noload", 32'(addr_log.size() - base), 32'd0);
      pulse_start();
      push_hdr(16'd1);
      push_word(32'h1234_5678);
`ifdef LOADER_CHECKSUM_EN
      push_word(32'h1234_5678);
`endif
      send_stream(0);
      wait_end();
      check_eq("t3c_done", {31'd0, done}, 32'd1);
      check_eq("t3c_error", {31'd0, error}, 32'd0);
      check_eq("t3c_nloads", 32'(addr_log.size() - base), 32'd1);
      if (addr_log.size() > base) begin
         check_eq("t3c_addr", addr_log[base], 32'h0);
         check_eq("t3c_inst", inst_log[base], 32'h1234_5678);
      end

      // 4: reset after 5 data bytes, then replay the full image
      pulse_start();
      push_hdr(16'd2);
      push_word(32'h2008_0005);
      stream.push_back(8'h00);
      send_stream(0);
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("t4_rst");
      rst = 1'b1;
      base = addr_log.size();
      @(negedge clk);
      check_eq("t4_idle_ready", {31'd0, byte_ready}, 32'd0);
      pulse_start();
      push_image2(32'h2008_000D);
      send_stream(0);
      wait_end();
      check_image2("t4", base);
      check_eq("t4_done", {31'd0, done}, 32'd1);

      // 5: start in DATA ignored; start in DONE re-enters LEN_HI
      base = addr_log.size();
      pulse_start();
      push_image2(32'h2008_000D);
      repeat (4) send_byte(stream.pop_front(), 0);
      pulse_start();
      send_stream(0);
      wait_end();
      check_image2("t5", base);
      check_eq("t5_done", {31'd0, done}, 32'd1);
      pulse_start();
      check_eq("t5_hold", {31'd0, cpu_hold}, 32'd1);
      check_eq("t5_done_clr", {31'd0, done}, 32'd0);
      check_eq("t5_lenhi_ready", {31'd0, byte_ready}, 32'd1);
      push_hdr(16'd0);
      send_stream(0);
      wait_end();
      check_eq("t5_error", {31'd0, error}, 32'd1);

      // 6: checksum trailer handling
      base = addr_log.size();
      pulse_start();
      push_image2(32'h2008_000D);
      send_stream(0);
      wait_end();
      check_image2("t6a", base);
      check_eq("t6a_done", {31'd0, done}, 32'd1);
`ifdef LOADER_CHECKSUM_EN
      base = addr_log.size();
      pulse_start();
      push_image2(32'h0000_0000);
      send_stream(0);
      wait_end();
      check_image2("t6b", base);
      check_eq("t6b_error", {31'd0, error}, 32'd1);
      check_eq("t6b_hold", {31'd0, cpu_hold}, 32'd1);
`else
      byte_valid = 1'b1;
      byte_data  = 8'h20;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("t6_no_trailer_ready", {31'd0, byte_ready}, 32'd0);
      end
      byte_valid = 1'b0;
      check_eq("t6_still_done", {31'd0, done}, 32'd1);
`endif

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
